gameover_seq: RTL and testbench
===============================

GAMEOVER_SEQ -- requirements
Module: gameover_seq

Interface
REQ-001 The block SHALL have parameter X_POS, default 312, meaning the banner left column in screen pixels.
REQ-002 The block SHALL have parameter START_Y, default 480, meaning the banner top row at rise start (just off-screen); it must be greater than TARGET_Y.
REQ-003 The block SHALL have parameter TARGET_Y, default 224, meaning the banner top row at rest.
REQ-004 The block SHALL have parameter HOLD_FRAMES, default 120, meaning the number of frames held before done; it must be at least 1.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single system clock.
REQ-006 The block SHALL have port Reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port frame_clk, input, 1 bit: vsync-derived frame strobe, synchronous to Clk.
REQ-008 The block SHALL have port trigger, input, 1 bit: a 1-cycle pulse that starts the game-over sequence.
REQ-009 The block SHALL have port skip, input, 1 bit: a 1-cycle pulse that finishes the rise immediately.
REQ-010 The block SHALL have port ack, input, 1 bit: a 1-cycle pulse that acknowledges done and returns to idle.
REQ-011 The block SHALL have ports DrawX and DrawY, input, 10 bits each: the current VGA pixel coordinate.
REQ-012 The block SHALL have ports sprite_row (output, 5 bits) and sprite_col (output, 4 bits): the banner ROM address.
REQ-013 The block SHALL have port banner_on, output, 1 bit: the current pixel lies inside the banner.
REQ-014 The block SHALL have ports busy and done, output, 1 bit each: the sequence is running, and the sequence is complete (level).

Function
REQ-015 A frame tick SHALL be a cycle with frame_clk=1 whose previous-cycle frame_clk was 0.
REQ-016 The FSM states SHALL be IDLE, RISE, HOLD and DONE.
REQ-017 In IDLE, trigger SHALL move the FSM to RISE on the next edge with banner_y<=START_Y; in all other states trigger SHALL be ignored.
REQ-018 In RISE, each tick SHALL decrement banner_y by 1; a tick with banner_y==TARGET_Y+1 SHALL set banner_y<=TARGET_Y, hold_cnt<=0 and move the FSM to HOLD.
REQ-019 In RISE, skip SHALL set banner_y<=TARGET_Y, hold_cnt<=0 and move the FSM to HOLD; skip SHALL win over a same-cycle tick; in other states skip SHALL be ignored.
REQ-020 In HOLD, each tick SHALL increment hold_cnt; a tick with hold_cnt==HOLD_FRAMES-1 SHALL move the FSM to DONE.
REQ-021 In DONE, the banner SHALL remain at TARGET_Y, and ack SHALL move the FSM to IDLE; ack SHALL win over a same-cycle trigger, and that trigger SHALL be dropped.
REQ-022 busy SHALL be 1 in RISE and HOLD; done SHALL be 1 in DONE; both SHALL be registered state decodes.
REQ-023 hit SHALL equal (state!=IDLE) && X_POS<=DrawX<=X_POS+15 && banner_y<=DrawY<=banner_y+31, with the compare done in 11-bit arithmetic so there is no wrap for banner_y up to 480.
REQ-024 The lookup outputs SHALL be registered with 1-cycle latency: banner_on<=hit; sprite_row<=DrawY-banner_y and sprite_col<=DrawX-X_POS when hit, else 0.

Reset
REQ-025 While Reset_n=0 at an edge, the block SHALL set state=IDLE, banner_y=START_Y, hold_cnt=0, banner_on=0, sprite_row=0, sprite_col=0, busy=0, done=0 and previous frame_clk=1, so no spurious tick occurs on release.
REQ-026 Reset asserted mid-sequence SHALL abort to IDLE at the next edge regardless of any input.

Configuration
REQ-027 With GAMEOVER_BLINK_EN defined, banner_on SHALL additionally be gated in HOLD by hold_cnt[3]==0, giving 8 frames on and 8 frames off; RISE and DONE SHALL be unaffected.
REQ-028 Without GAMEOVER_BLINK_EN, banner_on SHALL be ungated in every non-IDLE state.

Structure
REQ-029 The state enum and the constants SPRITE_W=16, SPRITE_H=32, SCREEN_W=640 and SCREEN_H=480 SHALL reside in shared package tank_pkg.
REQ-030 Edge detection SHALL be sub-module frame_tick_det (inputs Clk, Reset_n, frame_clk; output tick).

Verification
REQ-031 The bench SHALL use START_Y=40, TARGET_Y=36 and HOLD_FRAMES=3; trigger then 4 ticks -> banner_y 39,38,37,36; state HOLD after the 4th tick; busy=1 throughout.
REQ-032 Continuing REQ-031, 3 more ticks -> done=1 and busy=0; ack -> IDLE next cycle; a trigger on the ack cycle -> remains IDLE.
REQ-033 Trigger, 1 tick, then skip coincident with a tick -> banner_y=36 and state HOLD (no further decrement).
REQ-034 In HOLD at Y=36 with X_POS=312, DrawX=315 and DrawY=50 -> one cycle later banner_on=1, sprite_row=14, sprite_col=3; DrawX=328 -> banner_on=0 and row/col=0.
REQ-035 Reset_n low in HOLD with frame_clk held high -> IDLE, all outputs 0; after release, no tick until frame_clk goes low then high.
REQ-036 With GAMEOVER_BLINK_EN and HOLD_FRAMES=20, an in-banner pixel -> banner_on=1 for hold_cnt 0..7, 0 for 8..15, and 1 again from 16.

Source files
------------

// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tank_pkg
//  Description : Shared types and screen/sprite geometry for the tank game
//                display blocks. Holds the game-over sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package tank_pkg;

    localparam int SPRITE_W = 16;
    localparam int SPRITE_H = 32;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } go_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_tick_det.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_det
//  Description : Rising-edge detector for the vsync-derived frame strobe.
//                tick is high for the one cycle where frame_clk is 1 and was
//                0 on the previous cycle.
//  Ports       : Clk       - system clock
//                Reset_n   - synchronous active-low reset
//                frame_clk - frame strobe, synchronous to Clk
//                tick      - one-cycle frame tick (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_det (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);

    logic r_prev;

    // Previous value resets to 1 so a strobe already high when reset is
    // released does not look like a fresh edge.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= frame_clk;
        end
    end

    assign tick = frame_clk & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/gameover_seq.sv
`default_nettype none
// ============================================================================
//  Module      : gameover_seq
//  Description : Game-over banner sequencer. On trigger the banner rises from
//                START_Y to TARGET_Y one row per frame (skip jumps straight to
//                rest), holds for HOLD_FRAMES frames, then reports done until
//                acknowledged. Also produces the registered banner ROM address
//                and pixel-inside-banner flag for the current VGA coordinate.
//                Optional macro GAMEOVER_BLINK_EN blinks the banner during
//                HOLD (8 frames on, 8 frames off).
//  Ports       : Clk, Reset_n         - clock, synchronous active-low reset
//                frame_clk            - frame strobe
//                trigger, skip, ack   - one-cycle control pulses
//                DrawX, DrawY         - current pixel coordinate
//                sprite_row/col       - banner ROM address (1-cycle latency)
//                banner_on            - pixel inside banner (1-cycle latency)
//                busy, done           - sequence running / complete
//  Revision    : 1.0 - initial release
// ============================================================================
module gameover_seq
    import tank_pkg::*;
#(
    parameter int X_POS       = 312,
    parameter int START_Y     = 480,
    parameter int TARGET_Y    = 224,
    parameter int HOLD_FRAMES = 120
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       trigger,
    input  logic       skip,
    input  logic       ack,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [4:0] sprite_row,
    output logic [3:0] sprite_col,
    output logic       banner_on,
    output logic       busy,
    output logic       done
);

    // hold counter is at least 4 bits so bit 3 exists for the blink gate
    localparam int HCW = ($clog2(HOLD_FRAMES + 1) < 4) ? 4 : $clog2(HOLD_FRAMES + 1);

    localparam logic [9:0]     c_START_Y   = 10'(START_Y);
    localparam logic [9:0]     c_TARGET_Y  = 10'(TARGET_Y);
    localparam logic [9:0]     c_TARGET_P1 = 10'(TARGET_Y + 1);
    localparam logic [HCW-1:0] c_HOLD_LAST = HCW'(HOLD_FRAMES - 1);
    localparam logic [10:0]    c_X_LO      = 11'(X_POS);
    localparam logic [10:0]    c_X_HI      = 11'(X_POS + SPRITE_W - 1);
    localparam logic [10:0]    c_H_M1      = 11'(SPRITE_H - 1);
    localparam logic [3:0]     c_X_LO4     = 4'(X_POS);

    go_state_t      r_state;
    logic [9:0]     r_banner_y;
    logic [HCW-1:0] r_hold_cnt;

    logic        w_tick;
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic [10:0] w_by;
    logic        w_hit;
    logic        w_gate;

    frame_tick_det u_tick (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .tick      (w_tick)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM; busy/done are updated alongside each state change
    // so they always match the registered state.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_banner_y <= c_START_Y;
            r_hold_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (trigger) begin
                        r_state    <= RISE;
                        r_banner_y <= c_START_Y;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                RISE: begin
                    // skip takes priority over a tick in the same cycle
                    if (skip || (w_tick && (r_banner_y == c_TARGET_P1))) begin
                        r_state    <= HOLD;
                        r_banner_y <= c_TARGET_Y;
                        r_hold_cnt <= '0;
                    end else if (w_tick) begin
                        r_banner_y <= r_banner_y - 10'd1;
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_state <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // ack wins; a coincident trigger is simply not seen
                    if (ack) begin
                        r_state <= IDLE;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Banner hit test in 11 bits so banner_y+31 cannot wrap near 480.
    // ------------------------------------------------------------------
    assign w_dx  = {1'b0, DrawX};
    assign w_dy  = {1'b0, DrawY};
    assign w_by  = {1'b0, r_banner_y};
    assign w_hit = (r_state != IDLE)
                && (w_dx >= c_X_LO) && (w_dx <= c_X_HI)
                && (w_dy >= w_by)   && (w_dy <= (w_by + c_H_M1));

`ifdef GAMEOVER_BLINK_EN
    assign w_gate = !((r_state == HOLD) && r_hold_cnt[3]);
`else
    assign w_gate = 1'b1;
`endif

    // Offsets are taken modulo the sprite size; inside the banner they are
    // exact, so only the low bits of each coordinate are needed.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            banner_on  <= 1'b0;
            sprite_row <= '0;
            sprite_col <= '0;
        end else begin
            banner_on <= w_hit && w_gate;
            if (w_hit) begin
                sprite_row <= DrawY[4:0] - r_banner_y[4:0];
                sprite_col <= DrawX[3:0] - c_X_LO4;
            end else begin
                sprite_row <= '0;
                sprite_col <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gameover_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gameover_seq
//  Description : Self-checking bench for gameover_seq. Directed steps drive
//                rise, skip, hold, done/ack, pixel lookup and reset abort;
//                pixel lookups go through an expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gameover_seq;
    import tank_pkg::*;

`ifdef GAMEOVER_BLINK_EN
    localparam int HF    = 20;
    localparam bit BLINK = 1'b1;
`else
    localparam int HF    = 3;
    localparam bit BLINK = 1'b0;
`endif
    localparam int XP = 312;
    localparam int SY = 40;
    localparam int TY = 36;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic       trigger;
    logic       skip;
    logic       ack;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [4:0] sprite_row;
    logic [3:0] sprite_col;
    logic       banner_on;
    logic       busy;
    logic       done;

    gameover_seq #(
        .X_POS       (XP),
        .START_Y     (SY),
        .TARGET_Y    (TY),
        .HOLD_FRAMES (HF)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .trigger    (trigger),
        .skip       (skip),
        .ack        (ack),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .sprite_row (sprite_row),
        .sprite_col (sprite_col),
        .banner_on  (banner_on),
        .busy       (busy),
        .done       (done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       on;
        logic [4:0] row;
        logic [3:0] col;
    } pix_t;

    pix_t sbq[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   my;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame_tick();
        frame_clk = 1'b0;
        step();
        frame_clk = 1'b1;
        step();
    endtask

    // Reference lookup: banner occupies [XP,XP+15] x [by,by+31] when active.
    function automatic pix_t model(input int x, input int y, input bit active,
                                   input int by, input bit gate);
        pix_t p;
        bit   h;
        h     = active && (x >= XP) && (x <= XP + 15) && (y >= by) && (y <= by + 31);
        p.on  = h && gate;
        p.row = h ? 5'(y - by) : 5'd0;
        p.col = h ? 4'(x - XP) : 4'd0;
        return p;
    endfunction

    task automatic pix(input string tag, input int x, input int y, input bit active,
                       input int by, input bit gate);
        pix_t e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        sbq.push_back(model(x, y, active, by, gate));
        step();
        e = sbq.pop_front();
        chk({tag, "_on"},  32'(banner_on),  32'(e.on));
        chk({tag, "_row"}, 32'(sprite_row), 32'(e.row));
        chk({tag, "_col"}, 32'(sprite_col), 32'(e.col));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset_n   = 1'b0;
        frame_clk = 1'b1;
        trigger   = 1'b0;
        skip      = 1'b0;
        ack       = 1'b0;
        DrawX     = 10'd315;
        DrawY     = 10'd50;
        step();
        step();

        // reset state
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        chk("rst_y",     32'(dut.r_banner_y), 32'(SY));
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_on",    32'(banner_on), 32'd0);
        chk("rst_row",   32'(sprite_row), 32'd0);
        chk("rst_col",   32'(sprite_col), 32'd0);

        Reset_n = 1'b1;
        step();
        pix("idle_pix", 315, 50, 1'b0, SY, 1'b1);

        // rise: 4 ticks from 40 to 36
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        my = SY;
        chk("trig_busy", 32'(busy), 32'd1);
        chk("trig_y", 32'(dut.r_banner_y), 32'(my));
        for (int i = 0; i < 4; i++) begin
            frame_tick();
            my--;
            chk("rise_y", 32'(dut.r_banner_y), 32'(my));
            chk("rise_busy", 32'(busy), 32'd1);
            pix("rise_pix", 315, 50, 1'b1, my, 1'b1);
        end
        chk("hold_state", 32'(dut.r_state), 32'(HOLD));
        chk("hold_cnt0", 32'(dut.r_hold_cnt), 32'd0);

        // hold: HF ticks to done, banner visibility checked per hold count
        for (int k = 0; k < HF; k++) begin
            pix("hold_pix", 315, 50, 1'b1, TY, BLINK ? ((k & 8) == 0) : 1'b1);
            frame_tick();
            chk("hold_busy", 32'(busy), (k < HF - 1) ? 32'd1 : 32'd0);
            chk("hold_done", 32'(done), (k < HF - 1) ? 32'd0 : 32'd1);
        end
        chk("done_state", 32'(dut.r_state), 32'(DONE));
        chk("done_y", 32'(dut.r_banner_y), 32'(TY));
        pix("done_pix", 315, 50, 1'b1, TY, 1'b1);

        // trigger ignored in DONE
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("done_trig", 32'(done), 32'd1);

        // ack with coincident trigger: back to IDLE, trigger dropped
        ack     = 1'b1;
        trigger = 1'b1;
        step();
        ack     = 1'b0;
        trigger = 1'b0;
        chk("ack_state", 32'(dut.r_state), 32'(IDLE));
        chk("ack_done",  32'(done), 32'd0);
        chk("ack_busy",  32'(busy), 32'd0);
        step();
        chk("ack_stay", 32'(dut.r_state), 32'(IDLE));
        pix("ack_pix", 315, 50, 1'b0, TY, 1'b1);

        // skip coincident with a tick
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        frame_tick();
        chk("skip_pre_y", 32'(dut.r_banner_y), 32'(SY - 1));
        frame_clk = 1'b0;
        step();
        frame_clk = 1'b1;
        skip      = 1'b1;
        step();
        skip = 1'b0;
        chk("skip_y", 32'(dut.r_banner_y), 32'(TY));
        chk("skip_state", 32'(dut.r_state), 32'(HOLD));
        chk("skip_cnt", 32'(dut.r_hold_cnt), 32'd0);
        skip = 1'b1;
        step();
        skip = 1'b0;
        chk("skip_hold_ign", 32'(dut.r_hold_cnt), 32'd0);

        // pixel lookup and banner edges at rest (hold_cnt 0)
        pix("px_in",   315, 50, 1'b1, TY, 1'b1);
        chk("px_in_row14", 32'(sprite_row), 32'd14);
        chk("px_in_col3",  32'(sprite_col), 32'd3);
        pix("px_x328", 328, 50, 1'b1, TY, 1'b1);
        pix("px_x327", 327, 67, 1'b1, TY, 1'b1);
        pix("px_y68",  320, 68, 1'b1, TY, 1'b1);
        pix("px_x312", 312, 36, 1'b1, TY, 1'b1);
        pix("px_y35",  312, 35, 1'b1, TY, 1'b1);
        pix("px_x311", 311, 40, 1'b1, TY, 1'b1);

        // reset in HOLD with frame strobe high and every control asserted
        DrawX   = 10'd315;
        DrawY   = 10'd50;
        Reset_n = 1'b0;
        trigger = 1'b1;
        skip    = 1'b1;
        ack     = 1'b1;
        step();
        trigger = 1'b0;
        skip    = 1'b0;
        ack     = 1'b0;
        chk("mrst_state", 32'(dut.r_state), 32'(IDLE));
        chk("mrst_busy",  32'(busy), 32'd0);
        chk("mrst_done",  32'(done), 32'd0);
        chk("mrst_on",    32'(banner_on), 32'd0);
        chk("mrst_row",   32'(sprite_row), 32'd0);
        chk("mrst_col",   32'(sprite_col), 32'd0);
        chk("mrst_cnt",   32'(dut.r_hold_cnt), 32'd0);
        Reset_n = 1'b1;
        #1;
        chk("rel_no_tick", 32'(dut.w_tick), 32'd0);
        step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        step();
        step();
        chk("rel_y_hold", 32'(dut.r_banner_y), 32'(SY));
        frame_tick();
        chk("rel_y_tick", 32'(dut.r_banner_y), 32'(SY - 1));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
